// File: rtl/projb_pkg.sv
// Shared ProjectB definitions: the opcode set the control unit executes, the
// program loader's state encoding and the opcode field position in a word.
package projb_pkg;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;

   typedef enum logic [3:0] {
      NOOP  = 4'd0,
      STORE = 4'd1,
      LOAD  = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      HALT  = 4'd5
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WRITE,
      S_DONE,
      S_ERROR
   } ld_state_e;

   // Everything above HALT is unassigned and must never reach the memory.
   function automatic logic opc_legal(input logic [3:0] opc);
      return (opc <= 4'(HALT));
   endfunction

   function automatic logic opc_is_halt(input logic [3:0] opc);
      return (opc == 4'(HALT));
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the program loader. The master is the byte
// source; the slave is the loader, which owns byte_ready.
interface imem_loader_if;

   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_in, output byte_valid, input byte_ready);
   modport slave  (input byte_in, input byte_valid, output byte_ready);

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-pair assembler: high byte then low byte form one 16-bit
// word. word_rdy_o is high for the single cycle after the low byte lands.
module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        hi_en_i,
   input  logic        lo_en_i,
   input  logic [7:0]  byte_i,
   output logic [15:0] word_o,
   output logic        word_rdy_o
);

   logic [7:0] hi_q;
   logic [7:0] lo_q;
   logic       rdy_q;

   // Capture registers plus one-cycle word-ready pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_q  <= 8'h00;
         lo_q  <= 8'h00;
         rdy_q <= 1'b0;
      end else begin
         if (hi_en_i) hi_q <= byte_i;
         if (lo_en_i) lo_q <= byte_i;
         rdy_q <= lo_en_i;
      end
   end

   assign word_o     = {hi_q, lo_q};
   assign word_rdy_o = rdy_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader. Streams bytes into 16-bit words, writes
// them to consecutive addresses from 0, screens opcodes, and keeps the control
// unit in reset until a HALT-terminated program is fully in memory.
module imem_loader #(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   imem_loader_if.slave      bus,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   import projb_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wr_en_q, wr_en_d;
   logic              byte_rdy;
   logic              hi_en;
   logic              lo_en;
   logic [15:0]       word;
   logic              word_rdy;
   logic [3:0]        opc;

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .hi_en_i    (hi_en),
      .lo_en_i    (lo_en),
      .byte_i     (bus.byte_in),
      .word_o     (word),
      .word_rdy_o (word_rdy)
   );

   // The opcode lives in the high byte, so it is already known while the low
   // byte is being accepted; that lets the write strobe be registered.
   assign opc = word[OPC_MSB:OPC_LSB];

   // State, address pointer, word counter and write strobe registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         wr_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         wr_en_q <= wr_en_d;
      end
   end

   // Next-state, handshake and pointer/counter update logic.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      wr_en_d  = 1'b0;
      byte_rdy = 1'b0;
      hi_en    = 1'b0;
      lo_en    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_HI;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end
         S_HI: begin
            byte_rdy = 1'b1;
            if (bus.byte_valid) begin
               hi_en   = 1'b1;
               state_d = S_LO;
            end
         end
         S_LO: begin
            byte_rdy = 1'b1;
            if (bus.byte_valid) begin
               lo_en   = 1'b1;
               wr_en_d = opc_legal(opc);
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (word_rdy) begin
               if (!opc_legal(opc)) begin
                  state_d = S_ERROR;
               end else if (opc_is_halt(opc)) begin
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = S_DONE;
               end else if (ptr_q == LAST_ADDR) begin
                  // Memory is full and still no HALT: refuse to release the CPU.
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = S_ERROR;
               end else begin
                  ptr_d   = ptr_q + PTR_ONE;
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = S_HI;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.byte_ready = byte_rdy;
   assign wr_en          = wr_en_q;
   assign wr_addr        = ptr_q;
   assign wr_data        = word;
   assign word_count     = cnt_q;
   assign done           = (state_q == S_DONE);
   assign err            = (state_q == S_ERROR);
   assign cpu_hold       = (state_q != S_DONE);

endmodule
